// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register with EX-stage operand forwarding and load-use
//   hazard detection for the 5-stage pipelined CPU.
//
//   Ports
//     Clk, Rst          clock, synchronous active-high reset
//     Hold              freeze the back end; every register keeps its value
//     Flush             load a bubble instead of the ID instruction
//     D_*               decoded operands/controls from ID
//     M_Wreg/M_Rn/M_R   MEM-stage write-back candidate for forwarding
//     W_Wreg/W_Rn/W_D   WB-stage write-back candidate for forwarding
//     X, Y, Aluc        ALU operands and op
//     E_StData          store data (forwarded rt, never the immediate)
//     E_Rn/E_Wreg/E_M2reg/E_Wmem/E_Valid  registered controls to EX/MEM
//     LoadUse           combinational stall request towards IF/ID
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Hold,
   input  logic          Flush,
   input  logic [DW-1:0] D_Qa,
   input  logic [DW-1:0] D_Qb,
   input  logic [DW-1:0] D_Imm,
   input  logic [RW-1:0] D_Rs,
   input  logic [RW-1:0] D_Rt,
   input  logic [RW-1:0] D_Rn,
   input  logic [1:0]    D_Aluc,
   input  logic          D_Aluimm,
   input  logic          D_Wreg,
   input  logic          D_M2reg,
   input  logic          D_Wmem,
   input  logic          M_Wreg,
   input  logic [RW-1:0] M_Rn,
   input  logic [DW-1:0] M_R,
   input  logic          W_Wreg,
   input  logic [RW-1:0] W_Rn,
   input  logic [DW-1:0] W_D,
   output logic [DW-1:0] X,
   output logic [DW-1:0] Y,
   output logic [1:0]    Aluc,
   output logic [DW-1:0] E_StData,
   output logic [RW-1:0] E_Rn,
   output logic          E_Wreg,
   output logic          E_M2reg,
   output logic          E_Wmem,
   output logic          E_Valid,
   output logic          LoadUse
);

   logic          r_valid;
   logic          r_wreg;
   logic          r_m2reg;
   logic          r_wmem;
   logic [RW-1:0] r_rn;
   logic          r_aluimm;
   logic [1:0]    r_aluc;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [DW-1:0] r_qa;
   logic [DW-1:0] r_qb;
   logic [DW-1:0] r_imm;

   logic          w_bubble;
   logic          w_rt_used;
   logic [DW-1:0] w_fwd_a;
   logic [DW-1:0] w_fwd_b;

   // rt only matters as a source when it feeds the ALU (no immediate) or
   // supplies store data.
   assign w_rt_used = ~D_Aluimm | D_Wmem;

   assign LoadUse = r_valid & r_m2reg & r_wreg & (r_rn != '0) &
                    ((r_rn == D_Rs) | ((r_rn == D_Rt) & w_rt_used));

   assign w_bubble = Flush | LoadUse;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_valid  <= 1'b0;
         r_wreg   <= 1'b0;
         r_m2reg  <= 1'b0;
         r_wmem   <= 1'b0;
         r_rn     <= '0;
         r_aluimm <= 1'b0;
         r_aluc   <= 2'b00;
         r_rs     <= '0;
         r_rt     <= '0;
         r_qa     <= '0;
         r_qb     <= '0;
         r_imm    <= '0;
      end else if (!Hold) begin
         // Data fields load unconditionally; in a bubble they are dead
         // because every side-effecting control is cleared.
         r_aluimm <= D_Aluimm;
         r_aluc   <= D_Aluc;
         r_rs     <= D_Rs;
         r_rt     <= D_Rt;
         r_qa     <= D_Qa;
         r_qb     <= D_Qb;
         r_imm    <= D_Imm;
         if (w_bubble) begin
            r_valid <= 1'b0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
            r_rn    <= '0;
         end else begin
            r_valid <= 1'b1;
            r_wreg  <= D_Wreg;
            r_m2reg <= D_M2reg;
            r_wmem  <= D_Wmem;
            r_rn    <= D_Rn;
         end
      end
   end

   // MEM is checked first: it holds the younger result. r0 is hardwired zero,
   // so a nonzero destination is required before any forward.
   always_comb begin
      w_fwd_a = r_qa;
      if (M_Wreg && (M_Rn != '0) && (M_Rn == r_rs)) begin
         w_fwd_a = M_R;
      end else if (W_Wreg && (W_Rn != '0) && (W_Rn == r_rs)) begin
         w_fwd_a = W_D;
      end
   end

   always_comb begin
      w_fwd_b = r_qb;
      if (M_Wreg && (M_Rn != '0) && (M_Rn == r_rt)) begin
         w_fwd_b = M_R;
      end else if (W_Wreg && (W_Rn != '0) && (W_Rn == r_rt)) begin
         w_fwd_b = W_D;
      end
   end

   assign X        = w_fwd_a;
   assign Y        = r_aluimm ? r_imm : w_fwd_b;
   assign E_StData = w_fwd_b;
   assign Aluc     = r_aluc;
   assign E_Rn     = r_rn;
   assign E_Wreg   = r_wreg;
   assign E_M2reg  = r_m2reg;
   assign E_Wmem   = r_wmem;
   assign E_Valid  = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed bench: the stimulus process pushes a full expected output
//   snapshot tagged with the cycle it applies to; a monitor on the falling
//   edge pops and compares, so stimulus and checking stay independent.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

   logic        Clk;
   logic        Rst;
   logic        Hold;
   logic        Flush;
   logic [31:0] D_Qa;
   logic [31:0] D_Qb;
   logic [31:0] D_Imm;
   logic [4:0]  D_Rs;
   logic [4:0]  D_Rt;
   logic [4:0]  D_Rn;
   logic [1:0]  D_Aluc;
   logic        D_Aluimm;
   logic        D_Wreg;
   logic        D_M2reg;
   logic        D_Wmem;
   logic        M_Wreg;
   logic [4:0]  M_Rn;
   logic [31:0] M_R;
   logic        W_Wreg;
   logic [4:0]  W_Rn;
   logic [31:0] W_D;
   logic [31:0] X;
   logic [31:0] Y;
   logic [1:0]  Aluc;
   logic [31:0] E_StData;
   logic [4:0]  E_Rn;
   logic        E_Wreg;
   logic        E_M2reg;
   logic        E_Wmem;
   logic        E_Valid;
   logic        LoadUse;

   id_ex_operand_stage #(.DW(32), .RW(5)) dut (
      .Clk(Clk), .Rst(Rst), .Hold(Hold), .Flush(Flush),
      .D_Qa(D_Qa), .D_Qb(D_Qb), .D_Imm(D_Imm),
      .D_Rs(D_Rs), .D_Rt(D_Rt), .D_Rn(D_Rn),
      .D_Aluc(D_Aluc), .D_Aluimm(D_Aluimm), .D_Wreg(D_Wreg),
      .D_M2reg(D_M2reg), .D_Wmem(D_Wmem),
      .M_Wreg(M_Wreg), .M_Rn(M_Rn), .M_R(M_R),
      .W_Wreg(W_Wreg), .W_Rn(W_Rn), .W_D(W_D),
      .X(X), .Y(Y), .Aluc(Aluc), .E_StData(E_StData),
      .E_Rn(E_Rn), .E_Wreg(E_Wreg), .E_M2reg(E_M2reg), .E_Wmem(E_Wmem),
      .E_Valid(E_Valid), .LoadUse(LoadUse)
   );

   typedef struct {
      int          cyc;
      string       name;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] sd;
      logic [1:0]  aluc;
      logic [4:0]  rn;
      logic        valid;
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        lu;
      logic        chk;   // 0: data fields are don't-care (bubble)
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic mon_bad;
   int   cyc      = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc++;

   always @(negedge Clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         mon_e   = sb_q.pop_front();
         mon_bad = 1'b0;
         if (mon_e.cyc != cyc) begin
            $display("FAIL %s: expected at cycle %0d, seen at %0d", mon_e.name, mon_e.cyc, cyc);
            mon_bad = 1'b1;
         end else begin
            if (mon_e.chk) begin
               if (X !== mon_e.x) begin
                  $display("FAIL %s X: got %h want %h", mon_e.name, X, mon_e.x); mon_bad = 1'b1;
               end
               if (Y !== mon_e.y) begin
                  $display("FAIL %s Y: got %h want %h", mon_e.name, Y, mon_e.y); mon_bad = 1'b1;
               end
               if (E_StData !== mon_e.sd) begin
                  $display("FAIL %s StData: got %h want %h", mon_e.name, E_StData, mon_e.sd); mon_bad = 1'b1;
               end
               if (Aluc !== mon_e.aluc) begin
                  $display("FAIL %s Aluc: got %b want %b", mon_e.name, Aluc, mon_e.aluc); mon_bad = 1'b1;
               end
            end
            if (E_Rn !== mon_e.rn) begin
               $display("FAIL %s E_Rn: got %0d want %0d", mon_e.name, E_Rn, mon_e.rn); mon_bad = 1'b1;
            end
            if ({E_Valid, E_Wreg, E_M2reg, E_Wmem} !== {mon_e.valid, mon_e.wreg, mon_e.m2reg, mon_e.wmem}) begin
               $display("FAIL %s V/Wreg/M2reg/Wmem: got %b want %b", mon_e.name,
                        {E_Valid, E_Wreg, E_M2reg, E_Wmem},
                        {mon_e.valid, mon_e.wreg, mon_e.m2reg, mon_e.wmem});
               mon_bad = 1'b1;
            end
            if (LoadUse !== mon_e.lu) begin
               $display("FAIL %s LoadUse: got %b want %b", mon_e.name, LoadUse, mon_e.lu); mon_bad = 1'b1;
            end
         end
         n_vec++;
         if (mon_bad) n_bad++;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic expect_now(input string name,
                             input logic [31:0] x, input logic [31:0] y, input logic [31:0] sd,
                             input logic [1:0] aluc, input logic [4:0] rn,
                             input logic valid, input logic wreg, input logic m2reg,
                             input logic wmem, input logic lu, input logic chk);
      exp_t e;
      e.cyc = cyc; e.name = name; e.x = x; e.y = y; e.sd = sd; e.aluc = aluc;
      e.rn = rn; e.valid = valid; e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem;
      e.lu = lu; e.chk = chk;
      sb_q.push_back(e);
   endtask

   task automatic id_set(input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                         input logic [1:0] aluc, input logic aluimm, input logic wreg,
                         input logic m2reg, input logic wmem);
      D_Qa = qa; D_Qb = qb; D_Imm = imm; D_Rs = rs; D_Rt = rt; D_Rn = rn;
      D_Aluc = aluc; D_Aluimm = aluimm; D_Wreg = wreg; D_M2reg = m2reg; D_Wmem = wmem;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; Hold = 1'b0; Flush = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      M_Wreg = 1'b0; M_Rn = '0; M_R = '0;
      W_Wreg = 1'b0; W_Rn = '0; W_D = '0;
      tick(); tick();
      expect_now("reset", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);

      // add r3,r1,r2 with Qa=5 Qb=7
      Rst = 1'b0;
      id_set(32'd5, 32'd7, 0, 1, 2, 3, 2'b10, 0, 1, 0, 0);
      expect_now("add_pre", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      tick();
      Hold = 1'b1;
      expect_now("add_ex", 32'd5, 32'd7, 32'd7, 2'b10, 3, 1, 1, 0, 0, 0, 1);

      tick();
      M_Wreg = 1'b1; M_Rn = 5'd1; M_R = 32'h100;
      W_Wreg = 1'b1; W_Rn = 5'd1; W_D = 32'h200;
      expect_now("fwd_mem_wins", 32'h100, 32'd7, 32'd7, 2'b10, 3, 1, 1, 0, 0, 0, 1);
      tick();
      M_Wreg = 1'b0;
      expect_now("fwd_wb", 32'h200, 32'd7, 32'd7, 2'b10, 3, 1, 1, 0, 0, 0, 1);
      tick();
      M_Wreg = 1'b1; M_Rn = 5'd2; M_R = 32'h33; W_Wreg = 1'b0;
      expect_now("fwd_b_mem", 32'd5, 32'h33, 32'h33, 2'b10, 3, 1, 1, 0, 0, 0, 1);

      // lw r4,8(r1) followed by sub r5,r4,r6
      tick();
      M_Wreg = 1'b0; W_Wreg = 1'b0; Hold = 1'b0;
      id_set(32'h10, 0, 32'd8, 1, 4, 4, 2'b10, 1, 1, 1, 0);
      expect_now("lw_pre", 32'd5, 32'd7, 32'd7, 2'b10, 3, 1, 1, 0, 0, 0, 1);
      tick();
      id_set(32'h40, 32'h60, 0, 4, 6, 5, 2'b11, 0, 1, 0, 0);
      expect_now("lu_detect", 32'h10, 32'd8, 0, 2'b10, 4, 1, 1, 1, 0, 1, 1);
      tick();
      expect_now("lu_bubble", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      tick();
      id_set(0, 0, 32'd4, 0, 7, 7, 2'b10, 1, 1, 1, 0);
      expect_now("sub_ex", 32'h40, 32'h60, 32'h60, 2'b11, 5, 1, 1, 0, 0, 0, 1);

      // lw r7 in EX: rt match only hazards when rt is really read
      tick();
      Hold = 1'b1;
      id_set(0, 0, 0, 1, 7, 8, 2'b10, 1, 1, 0, 0);
      expect_now("lu_imm_rt", 0, 32'd4, 0, 2'b10, 7, 1, 1, 1, 0, 0, 1);
      tick();
      id_set(0, 0, 0, 1, 7, 0, 2'b10, 1, 0, 0, 1);
      expect_now("lu_store_rt", 0, 32'd4, 0, 2'b10, 7, 1, 1, 1, 0, 1, 1);
      tick();
      Hold = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick();

      // r0 must never be forwarded
      M_Wreg = 1'b1; M_Rn = 5'd0; M_R = 32'hDEAD;
      W_Wreg = 1'b1; W_Rn = 5'd0; W_D = 32'hBEEF;
      id_set(0, 0, 0, 0, 0, 9, 2'b01, 0, 1, 0, 0);
      tick();
      Hold = 1'b1; Flush = 1'b1;
      id_set(32'h11, 32'h22, 32'h33, 1, 2, 12, 2'b10, 0, 1, 0, 0);
      expect_now("r0_no_fwd", 0, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 1);

      // Hold overrides Flush
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_now("hold_flush", 0, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 1);
      end
      Hold = 1'b0;
      tick();
      Flush = 1'b0;
      expect_now("flush_bubble", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      tick();
      expect_now("after_flush", 32'h11, 32'h22, 32'h22, 2'b10, 12, 1, 1, 0, 0, 0, 1);

      // reset beats hold mid-operation
      Rst = 1'b1; Hold = 1'b1;
      tick();
      expect_now("rst_mid", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      tick();
      Rst = 1'b0; Hold = 1'b0;
      tick();

      if (sb_q.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations left unchecked, want 0", sb_q.size());
         n_bad = n_bad + sb_q.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
